lfsr_checker: RTL and testbench

- Receive-side partner of the 8-bit LFSR pattern generator.
- Takes the serial pseudo-random bit stream, self-seeds its own LFSR from the first 8 received bits, then predicts every following bit.
- Reports lock status, per-bit error pulses and a saturating error count.
- Sits at the far end of a serial link under test; consumes one bit per qualified clock.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_next.sv | 14 +
 rtl/lfsr_checker.sv | 134 +++++++++++++
 tb/tb_lfsr_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and checker pair.
// Both ends import the register width and default feedback mask from here.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;

  // x^8 + x^6 + x^5 + x^4 + 1 over register bits [7:0]
  localparam logic [LFSR_WIDTH-1:0] DEFAULT_TAPS = 8'b1011_1000;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_e;

endpackage

// File: rtl/lfsr_next.sv
// Feedback bit of the LFSR: parity of the register bits selected by TAPS.
// Used by both generator and checker so the two ends cannot drift apart.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] TAPS = DEFAULT_TAPS
) (
  input  logic [LFSR_WIDTH-1:0] s,
  output logic                  fb
);

  assign fb = ^(s & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-seeds from the first 8 received bits, then
// predicts each following bit and reports lock, error pulses and an error count.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] TAPS     = DEFAULT_TAPS,
  parameter int                    LOCK_CNT = 16,
  parameter int                    LOSS_CNT = 4,
  parameter int                    CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_count,
  output logic             locked,
  output logic             bit_error,
  output logic [CNT_W-1:0] err_count,
  output logic             seeding
);

  localparam int SEED_W = $clog2(LFSR_WIDTH);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_CNT + 1);

  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(LFSR_WIDTH - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CNT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                  state;
  logic [LFSR_WIDTH-1:0]   s;
  logic [SEED_W-1:0]       seed_cnt;
  logic [RUN_W-1:0]        cor_run;
  logic [LOSS_W-1:0]       err_run;

  logic                    fb_p0;
  logic [LFSR_WIDTH-1:0]   seed_word_p0;
  logic                    vld_p0;
  logic                    mismatch_p0;
  logic                    count_err_p0;

  lfsr_next #(
    .TAPS (TAPS)
  ) u_next (
    .s  (s),
    .fb (fb_p0)
  );

  // Stage p0: decode the sampled bit against the current prediction
  assign vld_p0       = bit_valid;
  assign seed_word_p0 = {s[LFSR_WIDTH-2:0], bit_in};
  assign mismatch_p0  = (bit_in != fb_p0);
  assign count_err_p0 = vld_p0 && (state == CHECK) && mismatch_p0;

  // Stage p1: registered state and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SEED;
      s         <= '0;
      seed_cnt  <= '0;
      cor_run   <= '0;
      err_run   <= '0;
      locked    <= 1'b0;
      bit_error <= 1'b0;
      err_count <= '0;
      seeding   <= 1'b1;
    end else begin
      bit_error <= 1'b0;

      if (clear_count) begin
        err_count <= '0;
      end else if (count_err_p0) begin
        err_count <= sat_inc(err_count);
      end

      if (vld_p0) begin
        case (state)
          SEED: begin
            s <= seed_word_p0;
            if (seed_cnt == SEED_LAST) begin
              seed_cnt <= '0;
              // An all-zero register would never leave zero; keep collecting.
              if (seed_word_p0 != '0) begin
                state   <= CHECK;
                seeding <= 1'b0;
                cor_run <= '0;
                err_run <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + 1'b1;
            end
          end

          CHECK: begin
            // Advance on the prediction so a corrupted bit never enters the register.
            s <= {s[LFSR_WIDTH-2:0], fb_p0};
            if (mismatch_p0) begin
              bit_error <= 1'b1;
              cor_run   <= '0;
              if (err_run == LOSS_LAST) begin
                err_run  <= '0;
                locked   <= 1'b0;
                state    <= SEED;
                seeding  <= 1'b1;
                seed_cnt <= '0;
              end else begin
                err_run <= err_run + 1'b1;
              end
            end else begin
              err_run <= '0;
              if (cor_run != RUN_FULL) begin
                cor_run <= cor_run + 1'b1;
              end
              if (cor_run == RUN_LAST || cor_run == RUN_FULL) begin
                locked <= 1'b1;
              end
            end
          end

          default: begin
            state   <= SEED;
            seeding <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a driver queues hand-derived expectations
// per cycle, a monitor pops and compares them after each rising edge.
module tb_lfsr_checker;

  localparam logic [7:0] TB_TAPS = 8'b1011_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_count;

  logic        locked,  bit_error,  seeding;
  logic [15:0] err_count;
  logic        locked4, bit_error4, seeding4;
  logic [3:0]  err_count4;

  always #5 clock = ~clock;

  lfsr_checker #(.TAPS(TB_TAPS), .LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .clear_count (clear_count),
    .locked      (locked),
    .bit_error   (bit_error),
    .err_count   (err_count),
    .seeding     (seeding)
  );

  lfsr_checker #(.TAPS(TB_TAPS), .LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(4)) dut4 (
    .clock       (clock),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .clear_count (clear_count),
    .locked      (locked4),
    .bit_error   (bit_error4),
    .err_count   (err_count4),
    .seeding     (seeding4)
  );

  typedef struct {
    int ph;
    bit ck;
    bit lock;
    bit seed;
    bit err;
    int cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       nx;
  int         errors = 0;
  int         checks = 0;
  int         ph = 0;
  logic [7:0] g;

  task automatic cmp(input int p, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL p%0d %s: got %0d expected %0d", p, name, act, exp);
    end
  endtask

  // Monitor: one queued expectation per driven cycle, checked 1ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.ck) begin
          cmp(e.ph, "locked",       {31'd0, locked},    {31'd0, e.lock});
          cmp(e.ph, "seeding",      {31'd0, seeding},   {31'd0, e.seed});
          cmp(e.ph, "bit_error",    {31'd0, bit_error}, {31'd0, e.err});
          cmp(e.ph, "err_count",    {16'd0, err_count}, e.cnt);
          cmp(e.ph, "err_count_w4", {28'd0, err_count4}, (e.cnt > 15) ? 15 : e.cnt);
          cmp(e.ph, "locked_w4",    {31'd0, locked4},   {31'd0, e.lock});
        end
      end
    end
  end

  task automatic next_bit(output logic b);
    b = g[7];
    g = {g[6:0], ^(g & TB_TAPS)};
  endtask

  task automatic expect_all(input bit lk, input bit sd, input bit er, input int cnt);
    nx.ck   = 1'b1;
    nx.lock = lk;
    nx.seed = sd;
    nx.err  = er;
    nx.cnt  = cnt;
  endtask

  task automatic drive(input logic r, input logic v, input logic b, input logic c);
    @(negedge clock);
    reset       = r;
    bit_valid   = v;
    bit_in      = b;
    clear_count = c;
    nx.ph = ph;
    q.push_back(nx);
    nx = '{default: 0};
  endtask

  initial begin
    logic b;
    int   n;
    bit   found;

    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear_count = 1'b0;
    nx = '{default: 0};
    g  = 8'h00;

    ph = 0;
    expect_all(0, 1, 0, 0); drive(1, 0, 0, 0);
    expect_all(0, 1, 0, 0); drive(1, 1, 1, 1);

    // Clean lock from seed D3: seeding ends after bit 8, lock after bit 24
    ph = 1; g = 8'hD3;
    for (int k = 1; k <= 200; k++) begin
      next_bit(b);
      expect_all(k >= 24, k < 8, 0, 0);
      drive(0, 1, b, 0);
    end

    // Single inverted bit while locked
    ph = 2;
    for (int k = 1; k <= 5; k++) begin
      next_bit(b); expect_all(1, 0, 0, 0); drive(0, 1, b, 0);
    end
    next_bit(b); expect_all(1, 0, 1, 1); drive(0, 1, ~b, 0);
    for (int k = 1; k <= 20; k++) begin
      next_bit(b); expect_all(1, 0, 0, 1); drive(0, 1, b, 0);
    end

    // Four consecutive errors drop lock, then clean relock
    ph = 3;
    expect_all(1, 0, 0, 0); drive(0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      next_bit(b); expect_all(i < 4, i == 4, 1, i); drive(0, 1, ~b, 0);
    end
    for (int k = 1; k <= 30; k++) begin
      next_bit(b); expect_all(k >= 24, k < 8, 0, 4); drive(0, 1, b, 0);
    end

    // Generator reloaded with B3: wait for loss, then relock with valid gaps
    ph = 4; g = 8'hB3;
    found = 1'b0;
    n = 0;
    while (n < 600 && !found) begin
      next_bit(b);
      drive(0, 1, b, 0);
      @(posedge clock);
      #1;
      if (seeding === 1'b1) found = 1'b1;
      n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL p4 reseed_timeout: got no loss expected loss within 600 bits");
    end
    next_bit(b); expect_all(0, 1, 0, 0); drive(0, 1, b, 1);
    for (int k = 2; k <= 30; k++) begin
      next_bit(b); expect_all(k >= 24, k < 8, 0, 0); drive(0, 1, b, 0);
      if (k % 5 == 0) begin
        for (int j = 0; j < 3; j++) begin
          expect_all(k >= 24, k < 8, 0, 0);
          drive(0, 0, 1'($urandom_range(0, 1)), 0);
        end
      end
    end

    // Eight zeros are rejected as a seed, then D3 seeds normally
    ph = 5;
    expect_all(0, 1, 0, 0); drive(1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      expect_all(0, 1, 0, 0); drive(0, 1, 0, 0);
    end
    g = 8'hD3;
    for (int k = 1; k <= 40; k++) begin
      next_bit(b); expect_all(k >= 24, k < 8, 0, 0); drive(0, 1, b, 0);
    end

    // Saturation (4-bit instance holds at 15), clear priority, reset in CHECK
    ph = 6;
    for (int i = 1; i <= 20; i++) begin
      next_bit(b); expect_all(1, 0, 1, i); drive(0, 1, ~b, 0);
      next_bit(b); expect_all(1, 0, 0, i); drive(0, 1, b, 0);
    end
    next_bit(b); expect_all(1, 0, 1, 0); drive(0, 1, ~b, 1);
    next_bit(b); expect_all(1, 0, 1, 1); drive(0, 1, ~b, 0);
    next_bit(b); expect_all(0, 1, 0, 0); drive(1, 1, ~b, 0);
    expect_all(0, 1, 0, 0); drive(0, 0, 0, 0);

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL p%0d scoreboard_drain: got %0d pending expected 0", ph, q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
